// File: rtl/ghost_pkg.sv
// ghost_pkg: shared ghost mode codes, ghost indices, direction constants and sequencer states
package ghost_pkg;
  typedef enum logic [3:0] {
    M_EATEN   = 4'b0001,
    M_FRIGHT  = 4'b0010,
    M_SCATTER = 4'b0100,
    M_CHASE   = 4'b1000
  } mode_t;
  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_GAP} seq_t;
  localparam logic [1:0] BLINKY = 2'd0;
  localparam logic [1:0] PINKY  = 2'd1;
  localparam logic [1:0] INKY   = 2'd2;
  localparam logic [1:0] CLYDE  = 2'd3;
  localparam logic [15:0] DIR_LEFT  = 16'hFF00;
  localparam logic [15:0] DIR_RIGHT = 16'h0100;
  localparam logic [15:0] DIR_UP    = 16'h00FF;
  localparam logic [15:0] DIR_DOWN  = 16'h0001;
endpackage

// File: rtl/mode_timer.sv
// mode_timer: scatter/chase phase table and frightened countdown, advanced by game ticks
// Ports: clk, rst (sync, active-high); tick, power pulses in;
// gmode = global phase mode, fright_active = fright count nonzero, phase_changed = pulse on the tick that advances the phase
module mode_timer
  import ghost_pkg::*;
#(
  parameter int SCATTER_TICKS = 420,
  parameter int CHASE_TICKS   = 1200,
  parameter int FRIGHT_TICKS  = 360
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  tick,
  input  logic  power,
  output mode_t gmode,
  output logic  fright_active,
  output logic  phase_changed
);
  localparam int PMAX = SCATTER_TICKS > CHASE_TICKS ? SCATTER_TICKS : CHASE_TICKS;
  localparam int PW = $clog2(PMAX + 1);
  localparam int FW = $clog2(FRIGHT_TICKS + 1);
  logic [2:0] phase;
  logic [PW-1:0] pcnt;
  logic [FW-1:0] fcnt;
  logic run;
  assign fright_active = fcnt != '0;
  // phase 7 is the endless chase, so its counter never moves
  assign run = tick && !fright_active && phase != 3'd7;
  assign phase_changed = run && pcnt <= PW'(1);
  assign gmode = phase[0] ? M_CHASE : M_SCATTER;
  always_ff @(posedge clk)
    if (rst) begin
      phase <= '0;
      pcnt <= PW'(SCATTER_TICKS);
      fcnt <= '0;
    end else begin
      fcnt <= power ? FW'(FRIGHT_TICKS) : (tick && fright_active) ? fcnt - 1'b1 : fcnt;
      phase <= phase_changed ? phase + 1'b1 : phase;
      pcnt <= phase_changed ? (phase[0] ? PW'(SCATTER_TICKS) : PW'(CHASE_TICKS)) : run ? pcnt - 1'b1 : pcnt;
    end
endmodule

// File: rtl/ghost_scheduler.sv
// ghost_scheduler: per-tick sweep of four ghost update windows plus per-ghost mode resolution
// Ports: sysclk, reset (sync, active-high); tick, power, ghost_eaten[4], ghost_home[4] in;
// update[4] one-hot window strobe, rotate[4] reverse request, mode[16] one-hot mode per ghost, busy, overrun (sticky)
module ghost_scheduler
  import ghost_pkg::*;
#(
  parameter int UPDATE_LEN    = 7,
  parameter int SCATTER_TICKS = 420,
  parameter int CHASE_TICKS   = 1200,
  parameter int FRIGHT_TICKS  = 360
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        tick,
  input  logic        power,
  input  logic [3:0]  ghost_eaten,
  input  logic [3:0]  ghost_home,
  output logic [3:0]  update,
  output logic [3:0]  rotate,
  output logic [15:0] mode,
  output logic        busy,
  output logic        overrun
);
  localparam int CW = $clog2(UPDATE_LEN + 1);
  seq_t state, state_n;
  logic [1:0] ghost, ghost_n;
  logic [CW-1:0] cnt, cnt_n;
  logic pending, pending_n, last_gap, start, fright_active, phase_changed;
  logic [3:0] update_n, enter, fr, rp_set, eaten, exempt, rp;
  mode_t gmode;
  mode_t res [4];
  mode_timer #(
    .SCATTER_TICKS(SCATTER_TICKS),
    .CHASE_TICKS(CHASE_TICKS),
    .FRIGHT_TICKS(FRIGHT_TICKS)
  ) u_timer (
    .clk(sysclk),
    .rst(reset),
    .tick(tick),
    .power(power),
    .gmode(gmode),
    .fright_active(fright_active),
    .phase_changed(phase_changed)
  );
  // the gap after the last ghost is not busy, so a tick there or a queued tick restarts at once
  assign last_gap = state == S_GAP && ghost == CLYDE;
  assign busy = state != S_IDLE && !last_gap;
  assign start = (state == S_IDLE || last_gap) && (tick || pending);
  assign update = state == S_SERVE ? 4'b1 << ghost : 4'b0;
  assign update_n = state_n == S_SERVE ? 4'b1 << ghost_n : 4'b0;
  assign enter = update_n & ~update;
  assign rp_set = (phase_changed || power) ? ~eaten : 4'b0;
  always_comb begin
    state_n = state;
    ghost_n = ghost;
    cnt_n = cnt;
    pending_n = pending;
    if (start) begin
      state_n = S_SERVE;
      ghost_n = BLINKY;
      cnt_n = '0;
      pending_n = pending && tick;
    end else if (state == S_SERVE) begin
      cnt_n = cnt + 1'b1;
      state_n = cnt == CW'(UPDATE_LEN - 1) ? S_GAP : S_SERVE;
    end else if (state == S_GAP) begin
      state_n = last_gap ? S_IDLE : S_SERVE;
      ghost_n = ghost + 1'b1;
      cnt_n = '0;
    end
    if (busy && tick) pending_n = 1'b1;
  end
  always_ff @(posedge sysclk)
    if (reset) begin
      state <= S_IDLE;
      ghost <= '0;
      cnt <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      ghost <= ghost_n;
      cnt <= cnt_n;
      pending <= pending_n;
      overrun <= overrun | (busy & tick & pending);
    end
  always_comb
    for (int i = 0; i < 4; i++) begin
      res[i] = eaten[i] ? M_EATEN : (fright_active && !exempt[i]) ? M_FRIGHT : gmode;
      fr[i] = res[i] == M_FRIGHT;
    end
  // pending reversals are consumed as a window opens; a request arriving on that same edge is included
  always_ff @(posedge sysclk)
    if (reset) begin
      eaten <= '0;
      exempt <= '0;
      rp <= '0;
      rotate <= '0;
      mode <= {4{M_SCATTER}};
    end else begin
      eaten <= (ghost_eaten & fr) | (eaten & ~ghost_home);
      exempt <= power ? 4'b0 : exempt | (ghost_eaten & fr);
      rp <= (rp | rp_set) & ~enter;
      rotate <= |enter ? enter & (rp | rp_set) : state_n == S_SERVE ? rotate : 4'b0;
      for (int i = 0; i < 4; i++)
        if (!(update[i] && update_n[i])) mode[4*i+:4] <= res[i];
    end
endmodule

// File: tb/tb_ghost_scheduler.sv
// tb_ghost_scheduler: table, directed and randomized checks against a sweep-timeline reference model
module tb_ghost_scheduler;
  localparam int L = 7, S = 3, C = 5, F = 4, SW = 4 * (L + 1);
  logic clk = 0, reset = 1, tick = 0, power = 0;
  logic [3:0] ge = 0, gh = 0;
  logic [3:0] update, rotate;
  logic [15:0] mode;
  logic busy, overrun;
  ghost_scheduler #(.UPDATE_LEN(L), .SCATTER_TICKS(S), .CHASE_TICKS(C), .FRIGHT_TICKS(F)) dut (
    .sysclk(clk), .reset(reset), .tick(tick), .power(power), .ghost_eaten(ge), .ghost_home(gh),
    .update(update), .rotate(rotate), .mode(mode), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, t = 0;
  int s, phase, elapsed, fright;
  bit pend, ovr, valid = 0;
  logic [3:0] eat, exm, rp, rot_val;
  logic [3:0] res_prev [4];
  logic [3:0] win_val [4];
  typedef struct {int cyc; logic [3:0] upd; logic bsy;} vec_t;
  vec_t tab [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  function automatic bit in_win(int i, int tt);
    int k = tt - s - 1;
    return k >= 0 && k < SW && k / (L + 1) == i && k % (L + 1) < L;
  endfunction

  function automatic logic [3:0] resolve(int i);
    if (eat[i]) return 4'b0001;
    if (fright > 0 && !exm[i]) return 4'b0010;
    return phase % 2 ? 4'b1000 : 4'b0100;
  endfunction

  task automatic model_reset();
    s = -1000000; pend = 0; ovr = 0; phase = 0; elapsed = 0; fright = 0;
    eat = 0; exm = 0; rp = 0; rot_val = 0;
    for (int i = 0; i < 4; i++) begin res_prev[i] = 4'b0100; win_val[i] = 4'b0100; end
  endtask

  task automatic model_step();
    logic [3:0] r [4];
    logic [3:0] setm, hon;
    bit pc = 0;
    int k = t - s - 1;
    for (int i = 0; i < 4; i++) r[i] = resolve(i);
    if (k >= 0 && k <= SW - 2) begin
      if (tick) begin if (pend) ovr = 1; else pend = 1; end
    end else if (tick || pend) begin
      s = t;
      pend = pend && tick;
    end
    if (tick && fright == 0 && phase < 7) begin
      elapsed++;
      if (elapsed == (phase % 2 ? C : S)) begin phase++; elapsed = 0; pc = 1; end
    end
    if (power) fright = F; else if (tick && fright > 0) fright--;
    setm = (pc || power) ? ~eat : 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (in_win(i, t + 1) && !in_win(i, t)) begin
        win_val[i] = r[i]; rot_val[i] = rp[i] | setm[i]; rp[i] = 0;
      end else rp[i] = rp[i] | setm[i];
      hon[i] = ge[i] && r[i] == 4'b0010;
      res_prev[i] = r[i];
    end
    eat = hon | (eat & ~gh);
    exm = power ? 4'b0 : exm | hon;
  endtask

  task automatic cyc();
    bit r = reset;
    logic [3:0] eu = 0, er = 0;
    logic [15:0] em;
    int k = t - s - 1;
    if (valid) begin
      for (int i = 0; i < 4; i++) begin
        em[4*i+:4] = in_win(i, t) ? win_val[i] : res_prev[i];
        if (in_win(i, t)) begin eu[i] = 1; er[i] = rot_val[i]; end
      end
      chk("update", update, eu);
      chk("busy", busy, k >= 0 && k <= SW - 2);
      chk("rotate", rotate, er);
      chk("mode", mode, em);
      chk("overrun", overrun, ovr);
    end
    if (r) model_reset(); else model_step();
    @(posedge clk); #1;
    t = r ? 0 : t + 1;
    valid |= r;
    reset = 0; tick = 0; power = 0; ge = 0; gh = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc();
  endtask

  task automatic sweep();
    tick = 1;
    repeat (SW + 2) cyc();
  endtask

  initial begin
    tab = '{'{1, 4'b0001, 1'b1}, '{7, 4'b0001, 1'b1}, '{8, 4'b0000, 1'b1}, '{9, 4'b0010, 1'b1},
            '{15, 4'b0010, 1'b1}, '{16, 4'b0000, 1'b1}, '{17, 4'b0100, 1'b1}, '{24, 4'b0000, 1'b1},
            '{25, 4'b1000, 1'b1}, '{31, 4'b1000, 1'b1}, '{32, 4'b0000, 1'b0}, '{33, 4'b0000, 1'b0}};
    do_reset();
    chk("rst_update", update, 4'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rotate", rotate, 4'b0);
    chk("rst_mode", mode, 16'h4444);
    chk("rst_overrun", overrun, 1'b0);
    tick = 1;
    foreach (tab[j]) begin
      while (t < tab[j].cyc) cyc();
      chk("tab_update", update, tab[j].upd);
      chk("tab_busy", busy, tab[j].bsy);
    end
    // phase change to chase and the reversal sweep
    do_reset();
    sweep(); sweep();
    chk("scatter_mode", mode, 16'h4444);
    tick = 1;
    cyc();
    for (int g = 0; g < 4; g++) begin
      chk("rot_win", rotate, 4'b1 << g);
      repeat (L) cyc();
      chk("rot_gap", rotate, 4'b0);
      cyc();
    end
    cyc();
    chk("chase_mode", mode, 16'h8888);
    tick = 1;
    cyc();
    chk("rot_next", rotate, 4'b0);
    repeat (SW + 1) cyc();
    // fright, eaten, second power, home, expiry
    power = 1; cyc(); cyc();
    chk("fright_all", mode, 16'h2222);
    ge = 4'b0100; cyc(); cyc();
    chk("inky_eaten", mode, 16'h2122);
    power = 1; cyc(); cyc();
    chk("repower", mode, 16'h2122);
    gh = 4'b0100; cyc(); cyc();
    chk("inky_home", mode, 16'h2222);
    repeat (F) sweep();
    chk("fright_end", mode, 16'h8888);
    repeat (C - 2) sweep();
    chk("chase_held", mode, 16'h8888);
    sweep();
    chk("back_scatter", mode, 16'h4444);
    // pending tick and overrun
    do_reset();
    tick = 1; cyc(); cyc(); cyc();
    tick = 1; cyc(); cyc();
    tick = 1; cyc();
    chk("overrun", overrun, 1'b1);
    while (t < 33) cyc();
    chk("sweep2_update", update, 4'b0001);
    chk("sweep2_busy", busy, 1'b1);
    while (t < 66) cyc();
    chk("no_sweep3_update", update, 4'b0);
    chk("no_sweep3_busy", busy, 1'b0);
    // power inside ghost 2's window
    do_reset();
    tick = 1;
    while (t < 19) cyc();
    power = 1; cyc();
    while (t < 24) begin
      chk("win2_mode", mode[11:8], 4'b0100);
      chk("win2_rot", rotate[2], 1'b0);
      cyc();
    end
    cyc();
    chk("win3_mode", mode[15:12], 4'b0010);
    chk("win3_rot", rotate[3], 1'b1);
    // reset in the middle of ghost 1's window
    do_reset();
    tick = 1;
    while (t < 12) cyc();
    reset = 1; cyc();
    chk("mid_rst_update", update, 4'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rotate", rotate, 4'b0);
    chk("mid_rst_mode", mode, 16'h4444);
    chk("mid_rst_overrun", overrun, 1'b0);
    tick = 1; cyc();
    chk("restart", update, 4'b0001);
    // randomized traffic against the model
    do_reset();
    repeat (4000) begin
      tick = $urandom_range(0, 19) == 0;
      power = $urandom_range(0, 149) == 0;
      ge = $urandom_range(0, 5) == 0 ? 4'($urandom) : 4'b0;
      gh = $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'b0;
      reset = $urandom_range(0, 1999) == 0;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ghost_scheduler.md
GHOST_SCHEDULER -- requirements
Module: ghost_scheduler

Interface
REQ-001 Parameter UPDATE_LEN, default 7, is the number of cycles each ghost's update strobe is held high; one cycle per ghost FSM state.
REQ-002 Parameter SCATTER_TICKS, default 420, is the scatter phase length in game ticks.
REQ-003 Parameter CHASE_TICKS, default 1200, is the chase phase length in game ticks.
REQ-004 Parameter FRIGHT_TICKS, default 360, is the frightened period length in game ticks.
REQ-005 sysclk  in  1  sole clock; all state changes on posedge sysclk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 tick  in  1  one-cycle game-tick pulse.
REQ-008 power  in  1  one-cycle pulse: pacman ate an energizer.
REQ-009 ghost_eaten  in  4  per-ghost pulse: pacman caught ghost i (0 Blinky, 1 Pinky, 2 Inky, 3 Clyde).
REQ-010 ghost_home  in  4  per-ghost pulse: eaten ghost i reached the ghost house.
REQ-011 update  out  4  one-hot or zero; bit i is ghost i's update strobe.
REQ-012 rotate  out  4  bit i is the reverse-direction request for ghost i.
REQ-013 mode  out  16  mode[4i+3:4i] is ghost i's one-hot mode: Chase 1000, Scatter 0100, Frightened 0010, Eaten 0001.
REQ-014 busy  out  1  high while any update window or inter-ghost gap is in progress.
REQ-015 overrun  out  1  sticky; set when a tick is dropped.

Function
REQ-016 The sequencer SHALL have states IDLE, SERVE, GAP.
- IDLE -> SERVE(ghost 0) on tick or a pending tick.
- SERVE(i) holds update[i]=1 for exactly UPDATE_LEN cycles, then goes to GAP.
- GAP lasts 1 cycle with update=0. It then goes to SERVE(i+1), or to IDLE after ghost 3.
REQ-017 First update[0] SHALL rise on the cycle after tick is sampled; a full sweep SHALL be 4*(UPDATE_LEN+1) cycles.
REQ-018 A tick while busy SHALL set a one-deep pending flag, serviced on the IDLE entry cycle. A tick while pending is already set SHALL be dropped and SHALL set overrun.
REQ-019 Mode timers SHALL advance on every tick, regardless of sequencer state.
REQ-020 The phase table SHALL be S,C,S,C,S,C,S,C. The first seven phases use SCATTER_TICKS/CHASE_TICKS; phase 7 (chase) is infinite. The phase index saturates at 7.
REQ-021 While the fright counter is nonzero, the phase counter SHALL pause.
REQ-022 power SHALL load the fright counter with FRIGHT_TICKS, including when it is already nonzero, and SHALL clear all per-ghost fright-exempt flags.
REQ-023 Ghost i's mode SHALL be resolved by the first matching rule:
- eaten_flag[i] set: Eaten.
- fright counter nonzero and exempt[i] clear: Frightened.
- otherwise: the global phase mode.
REQ-024 ghost_eaten[i] SHALL be honoured only while ghost i is Frightened. It sets eaten_flag[i] and exempt[i]; otherwise it is ignored.
REQ-025 ghost_home[i] SHALL clear eaten_flag[i]. If ghost_eaten[i] and ghost_home[i] arrive in the same cycle, eaten wins.
REQ-026 The mode[i] field SHALL be sampled into its output register on the cycle update[i] rises, and held constant through that window. Outside windows it SHALL track the resolved mode with 1-cycle latency.
REQ-027 rotate_pending[i] SHALL be set when either occurs, unless ghost i is Eaten:
- the global phase changes;
- power is applied.
REQ-028 rotate[i] SHALL equal rotate_pending[i] registered at window start and held for the whole SERVE(i) window. rotate_pending[i] SHALL clear at window end unless it was set again during that window.
REQ-029 All arithmetic SHALL be unsigned. Counters SHALL be sized by $clog2 of their max parameter and SHALL never wrap below zero.

Reset
REQ-030 reset SHALL force, on the next edge, in every state including mid-window:
- update=0, rotate=0, busy=0, overrun=0;
- mode=all ghosts Scatter (0100 x4);
- phase index 0 with counter=SCATTER_TICKS;
- fright counter 0;
- eaten, exempt, pending and rotate_pending flags cleared;
- sequencer in IDLE.

Structure
REQ-031 Mode one-hot codes, ghost indices and direction constants (LEFT FF00, RIGHT 0100, UP 00FF, DOWN 0001) SHALL live in shared package ghost_pkg, used by all ghost modules.
REQ-032 Phase and fright timing SHALL be one sub-module, mode_timer, which outputs the global mode, fright_active and a phase_changed pulse. The sequencer and per-ghost mode logic SHALL stay in ghost_scheduler.

Verification
REQ-033 UPDATE_LEN=7. Reset, then tick at cycle 0 -> update = 0001 for cycles 1-7, 0 at cycle 8, 0010 for cycles 9-15, and so on; busy falls at cycle 32.
REQ-034 SCATTER_TICKS=3, CHASE_TICKS=5. 3 ticks -> all modes go 0100 -> 1000; the next sweep has rotate=1 in each ghost's window only, then 0.
REQ-035 power in Chase -> all modes 0010. ghost_eaten=0100 -> Inky 0001. A second power -> Inky stays 0001, others 0010. ghost_home=0100 -> Inky 0010. FRIGHT_TICKS ticks later all ghosts return to Chase, with phase count unchanged.
REQ-036 Tick at sweep cycle 3 -> second sweep starts immediately after the first. A third tick during the same sweep -> overrun=1, and only two sweeps run.
REQ-037 power asserted mid SERVE(2) -> mode[11:8] and rotate[2] unchanged until the next window; mode[15:12] shows 0010 at ghost 3's window.
REQ-038 reset at cycle 4 of SERVE(1) -> update=0000 on the next cycle, all outputs at reset values, and a tick restarts from ghost 0.
